// File: rtl/llc_set_ctrl.sv
// rtl/llc_set_ctrl.sv - request-processing controller for the 16-way MESI LLC
//
// Accepts one request at a time, looks up the addressed set, updates MESI and
// tree-PLRU state and returns hit/miss, bus action, snoop result and any
// dirty-victim writeback. Set storage is held internally and initialised by
// the CLEAR walk after reset or on op 8.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_op/req_addr/req_shared  operation, byte address, shared hint for read fills
//   resp_valid/resp_ready     response handshake, fields held until consumed
//   resp_hit/resp_way/resp_mesi  lookup result and final MESI of the way
//   resp_bus_op/resp_snoop    bus action and snoop result
//   resp_wb/resp_wb_addr      modified line written back and its line address
//   resp_err                  unsupported op, no state change
//   st_hits/st_misses/st_reads/st_writes  statistics counters
//
// Optional feature: define LLC_STATS_EN to enable the saturating statistics
// counters; otherwise st_* are tied to zero.
module llc_set_ctrl #(
    parameter int ADDR_SIZE = 32,
    parameter int LINE_SIZE = 64,
    parameter int N_WAY     = 16,
    parameter int NUM_SETS  = 16384
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_op,
    input  logic [ADDR_SIZE-1:0]     req_addr,
    input  logic                     req_shared,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_hit,
    output logic [$clog2(N_WAY)-1:0] resp_way,
    output logic [1:0]               resp_mesi,
    output logic [2:0]               resp_bus_op,
    output logic [1:0]               resp_snoop,
    output logic                     resp_wb,
    output logic [ADDR_SIZE-1:0]     resp_wb_addr,
    output logic                     resp_err,
    output logic [31:0]              st_hits,
    output logic [31:0]              st_misses,
    output logic [31:0]              st_reads,
    output logic [31:0]              st_writes
);
    localparam int OFFSET_SIZE = $clog2(LINE_SIZE);
    localparam int INDEX_SIZE  = $clog2(NUM_SETS);
    localparam int TAG_SIZE    = ADDR_SIZE - OFFSET_SIZE - INDEX_SIZE;
    localparam int WAY_W       = $clog2(N_WAY);

    localparam logic [1:0] MESI_I = 2'b00, MESI_S = 2'b01, MESI_M = 2'b10, MESI_E = 2'b11;
    localparam logic [3:0] OP_RD = 4'd0, OP_WR = 4'd1, OP_IFETCH = 4'd2, OP_SNP_INV = 4'd3,
                           OP_SNP_RD = 4'd4, OP_SNP_RWIM = 4'd6, OP_CLEAR = 4'd8;
    localparam logic [2:0] BUS_NONE = 3'd0, BUS_READ = 3'd1, BUS_INV = 3'd3, BUS_RWIM = 3'd4;
    localparam logic [1:0] SNP_NOHIT = 2'd0, SNP_HIT = 2'd1, SNP_HITM = 2'd2;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [1:0]          mesi;
        logic [TAG_SIZE-1:0] tag;
    } line_st;

    typedef struct packed {
        line_st [N_WAY-1:0] ways;
        logic   [N_WAY-2:0] plru;
    } set_st;

    typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_LOOKUP, ST_UPDATE, ST_RESP} state_t;

    function automatic line_st make_line(input logic [1:0] mesi, input logic [TAG_SIZE-1:0] tag);
        make_line = '{valid: (mesi != MESI_I), dirty: (mesi == MESI_M), mesi: mesi, tag: tag};
    endfunction

    set_st set_mem [NUM_SETS];

    state_t                state, state_n;
    logic [3:0]            op_q;
    logic [TAG_SIZE-1:0]   tag_q;
    logic [INDEX_SIZE-1:0] idx_q, clr_idx;
    logic                  shared_q, clr_resp;
    set_st                 set_q;

    logic                  hit, inv_found, is_cpu, upd_we, plru_we;
    logic [WAY_W-1:0]      hit_way, inv_way, plru_way, victim_way, acc_way, node;
    logic [1:0]            cur_mesi, new_mesi;
    line_st                victim, upd_line;
    logic [N_WAY-2:0]      plru_n;
    logic                  n_hit, n_wb, n_err;
    logic [1:0]            n_mesi, n_snoop;
    logic [2:0]            n_bus;
    logic [ADDR_SIZE-1:0]  n_wb_addr;

    // Byte offset within the line never influences the set state.
    logic unused_offset;
    assign unused_offset = ^req_addr[OFFSET_SIZE-1:0];

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_CLEAR;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_CLEAR:  if (clr_idx == INDEX_SIZE'(NUM_SETS - 1)) state_n = clr_resp ? ST_RESP : ST_IDLE;
            ST_IDLE:   if (req_valid) state_n = (req_op == OP_CLEAR) ? ST_CLEAR : ST_LOOKUP;
            ST_LOOKUP: state_n = ST_UPDATE;
            ST_UPDATE: state_n = ST_RESP;
            ST_RESP:   if (resp_ready) state_n = ST_IDLE;
            default:   state_n = ST_CLEAR;
        endcase
    end

    // Lookup, victim choice and MESI/PLRU update, all evaluated on the set
    // captured during LOOKUP.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < N_WAY; w++) begin
            if (set_q.ways[w].valid && set_q.ways[w].tag == tag_q) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!set_q.ways[w].valid && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end

        // Tree walk: the way bits chosen so far select the node of the next level.
        plru_way = '0;
        node     = '0;
        for (int l = 0; l < WAY_W; l++) begin
            node = WAY_W'((1 << l) - 1) + (plru_way >> (WAY_W - l));
            plru_way[WAY_W-1-l] = set_q.plru[node];
        end
        victim_way = inv_found ? inv_way : plru_way;
        victim     = set_q.ways[victim_way];
        cur_mesi   = set_q.ways[hit_way].mesi;
        acc_way    = hit ? hit_way : victim_way;

        // Each node on the accessed path points to the opposite subtree.
        plru_n = set_q.plru;
        for (int l = 0; l < WAY_W; l++) begin
            node = WAY_W'((1 << l) - 1) + (acc_way >> (WAY_W - l));
            plru_n[node] = ~acc_way[WAY_W-1-l];
        end

        is_cpu    = (op_q == OP_RD) || (op_q == OP_WR) || (op_q == OP_IFETCH);
        upd_we    = 1'b0;
        plru_we   = 1'b0;
        new_mesi  = cur_mesi;
        n_hit     = 1'b0;
        n_mesi    = MESI_I;
        n_bus     = BUS_NONE;
        n_snoop   = SNP_NOHIT;
        n_wb      = 1'b0;
        n_wb_addr = '0;
        n_err     = 1'b0;
        case (op_q)
            OP_RD, OP_IFETCH, OP_WR: begin
                upd_we  = 1'b1;
                plru_we = 1'b1;
                n_hit   = hit;
                if (hit) begin
                    if (op_q == OP_WR) begin
                        new_mesi = MESI_M;
                        n_bus    = (cur_mesi == MESI_S) ? BUS_INV : BUS_NONE;
                    end
                end else begin
                    if (victim.dirty) begin
                        n_wb      = 1'b1;
                        n_wb_addr = {victim.tag, idx_q, {OFFSET_SIZE{1'b0}}};
                    end
                    new_mesi = (op_q == OP_WR) ? MESI_M : (shared_q ? MESI_S : MESI_E);
                    n_bus    = (op_q == OP_WR) ? BUS_RWIM : BUS_READ;
                end
                n_mesi = new_mesi;
            end
            OP_SNP_INV, OP_SNP_RD, OP_SNP_RWIM: begin
                if (hit) begin
                    upd_we  = 1'b1;
                    n_hit   = 1'b1;
                    n_snoop = SNP_HIT;
                    if (cur_mesi == MESI_M && op_q != OP_SNP_INV) begin
                        n_snoop   = SNP_HITM;
                        n_wb      = 1'b1;
                        n_wb_addr = {tag_q, idx_q, {OFFSET_SIZE{1'b0}}};
                    end
                    if (op_q == OP_SNP_RD)        new_mesi = MESI_S;
                    else if (op_q == OP_SNP_RWIM) new_mesi = MESI_I;
                    else if (cur_mesi == MESI_S)  new_mesi = MESI_I;
                    n_mesi = new_mesi;
                end
            end
            default: n_err = 1'b1;
        endcase
        upd_line = make_line(new_mesi, tag_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0; tag_q <= '0; idx_q <= '0; shared_q <= 1'b0;
            clr_idx <= '0; clr_resp <= 1'b0; set_q <= '0;
            resp_hit <= 1'b0; resp_way <= '0; resp_mesi <= '0; resp_bus_op <= '0;
            resp_snoop <= '0; resp_wb <= 1'b0; resp_wb_addr <= '0; resp_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    op_q     <= req_op;
                    tag_q    <= req_addr[ADDR_SIZE-1 -: TAG_SIZE];
                    idx_q    <= req_addr[OFFSET_SIZE +: INDEX_SIZE];
                    shared_q <= req_shared;
                    resp_hit <= 1'b0; resp_way <= '0; resp_mesi <= '0; resp_bus_op <= '0;
                    resp_snoop <= '0; resp_wb <= 1'b0; resp_wb_addr <= '0; resp_err <= 1'b0;
                    if (req_op == OP_CLEAR) begin
                        clr_resp <= 1'b1;
                        clr_idx  <= '0;
                    end
                end
                ST_CLEAR:  clr_idx <= clr_idx + 1'b1;
                ST_LOOKUP: set_q <= set_mem[idx_q];
                ST_UPDATE: begin
                    resp_hit     <= n_hit;
                    resp_way     <= (n_hit || is_cpu) ? acc_way : '0;
                    resp_mesi    <= n_mesi;
                    resp_bus_op  <= n_bus;
                    resp_snoop   <= n_snoop;
                    resp_wb      <= n_wb;
                    resp_wb_addr <= n_wb_addr;
                    resp_err     <= n_err;
                end
                ST_RESP: if (resp_ready) clr_resp <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                set_mem[clr_idx] <= '0;
            end else if (state == ST_UPDATE) begin
                if (upd_we)  set_mem[idx_q].ways[acc_way] <= upd_line;
                if (plru_we) set_mem[idx_q].plru <= plru_n;
            end
        end
    end

`ifdef LLC_STATS_EN
    logic [31:0] hits_q, misses_q, reads_q, writes_q;

    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && req_valid && req_op == OP_CLEAR)) begin
            hits_q <= '0; misses_q <= '0; reads_q <= '0; writes_q <= '0;
        end else if (state == ST_UPDATE && is_cpu) begin
            if (hit && hits_q != '1)   hits_q   <= hits_q + 1'b1;
            if (!hit && misses_q != '1) misses_q <= misses_q + 1'b1;
            if (op_q == OP_WR) begin
                if (writes_q != '1) writes_q <= writes_q + 1'b1;
            end else if (reads_q != '1) begin
                reads_q <= reads_q + 1'b1;
            end
        end
    end

    assign st_hits   = hits_q;
    assign st_misses = misses_q;
    assign st_reads  = reads_q;
    assign st_writes = writes_q;
`else
    assign st_hits   = '0;
    assign st_misses = '0;
    assign st_reads  = '0;
    assign st_writes = '0;
`endif

endmodule

// File: tb/tb_llc_set_ctrl.sv
// tb/tb_llc_set_ctrl.sv - self-checking bench for llc_set_ctrl against a behavioural cache model
module tb_llc_set_ctrl;
    localparam int NSETS = 16384;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_shared, resp_valid, resp_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, resp_wb_addr;
    logic        resp_hit, resp_wb, resp_err;
    logic [3:0]  resp_way;
    logic [1:0]  resp_mesi, resp_snoop;
    logic [2:0]  resp_bus_op;
    logic [31:0] st_hits, st_misses, st_reads, st_writes;

    always #5 clk = ~clk;

    llc_set_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_shared(req_shared),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hit(resp_hit), .resp_way(resp_way), .resp_mesi(resp_mesi),
        .resp_bus_op(resp_bus_op), .resp_snoop(resp_snoop),
        .resp_wb(resp_wb), .resp_wb_addr(resp_wb_addr), .resp_err(resp_err),
        .st_hits(st_hits), .st_misses(st_misses), .st_reads(st_reads), .st_writes(st_writes)
    );

    int checks = 0;
    int errors = 0;

    // Reference model over sets 0..3: MESI as 0=I 1=S 2=M 3=E.
    int  m_tag  [4][16];
    int  m_mesi [4][16];
    bit  m_plru [4][15];
    int  m_hits, m_misses, m_reads, m_writes;

    logic [13:0] e_vec, c_vec;
    logic [31:0] e_wba, c_wba;

    function automatic logic [13:0] pack(bit hit, int way, int mesi, int bus, int snp, bit wb, bit err);
        return {hit, 4'(way), 2'(mesi), 3'(bus), 2'(snp), wb, err};
    endfunction

    function automatic logic [127:0] exp_stats();
`ifdef LLC_STATS_EN
        return {32'(m_hits), 32'(m_misses), 32'(m_reads), 32'(m_writes)};
`else
        return '0;
`endif
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 16; w++) begin m_tag[s][w] = 0; m_mesi[s][w] = 0; end
            for (int n = 0; n < 15; n++) m_plru[s][n] = 0;
        end
        m_hits = 0; m_misses = 0; m_reads = 0; m_writes = 0;
    endtask

    task automatic model_req(input logic [3:0] op, input logic [31:0] addr, input bit shared);
        int s, t, w, node, lo, size, half, bus, snp, old;
        bit hit, wb;
        s = int'(addr[19:6]); t = int'(addr[31:20]);
        e_vec = '0; e_wba = '0; hit = 0; wb = 0; w = 0; bus = 0; snp = 0;
        if (op == 8) begin model_clear(); return; end
        for (int i = 0; i < 16; i++)
            if (m_mesi[s][i] != 0 && m_tag[s][i] == t) begin hit = 1; w = i; end
        if (op == 0 || op == 1 || op == 2) begin
            if (op == 1) m_writes++; else m_reads++;
            if (hit) m_hits++; else m_misses++;
            if (hit) begin
                if (op == 1) begin
                    if (m_mesi[s][w] == 1) bus = 3;
                    m_mesi[s][w] = 2;
                end
            end else begin
                w = -1;
                for (int i = 15; i >= 0; i--) if (m_mesi[s][i] == 0) w = i;
                if (w < 0) begin
                    node = 0;
                    while (node < 15) node = 2 * node + 1 + int'(m_plru[s][node]);
                    w = node - 15;
                end
                if (m_mesi[s][w] == 2) begin
                    wb = 1;
                    e_wba = (32'(m_tag[s][w]) << 20) | (32'(s) << 6);
                end
                m_tag[s][w]  = t;
                m_mesi[s][w] = (op == 1) ? 2 : (shared ? 1 : 3);
                bus = (op == 1) ? 4 : 1;
            end
            node = 0; lo = 0; size = 16;
            while (size > 1) begin
                half = size / 2;
                if (w < lo + half) begin m_plru[s][node] = 1; node = 2 * node + 1; end
                else begin m_plru[s][node] = 0; node = 2 * node + 2; lo += half; end
                size = half;
            end
            e_vec = pack(hit, w, m_mesi[s][w], bus, 0, wb, 0);
        end else if (op == 3 || op == 4 || op == 6) begin
            if (hit) begin
                old = m_mesi[s][w];
                snp = 1;
                if (old == 2 && op != 3) begin
                    snp = 2; wb = 1;
                    e_wba = (32'(t) << 20) | (32'(s) << 6);
                end
                if (op == 4) m_mesi[s][w] = 1;
                else if (op == 6) m_mesi[s][w] = 0;
                else if (old == 1) m_mesi[s][w] = 0;
                e_vec = pack(1, w, m_mesi[s][w], 0, snp, wb, 0);
            end
        end else begin
            e_vec = pack(0, 0, 0, 0, 0, 0, 1);
        end
    endtask

    // Issue one request, update the model and wait for the response.
    task automatic send_req(input logic [3:0] op, input logic [31:0] addr, input bit shared, output int lat);
        int n;
        model_req(op, addr, shared);
        req_op = op; req_addr = addr; req_shared = shared; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < NSETS + 50) begin @(posedge clk); #1; lat++; end
        if (resp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL resp_timeout op=%0d got resp_valid=%b want 1", op, resp_valid);
        end
        c_vec = {resp_hit, resp_way, resp_mesi, resp_bus_op, resp_snoop, resp_wb, resp_err};
        c_wba = resp_wb_addr;
    endtask

    task automatic ack_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_hit, resp_way, resp_mesi, resp_bus_op, resp_snoop, resp_wb,
             resp_wb_addr, resp_err, st_hits, st_misses, st_reads, st_writes} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b valid=%b wb_addr=%h want all zero", req_ready, resp_valid, resp_wb_addr);
        end
        rst = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < NSETS + 10) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== NSETS) begin
            errors++;
            $display("FAIL reset_clear_cycles got %0d want %0d", n, NSETS);
        end
        model_clear();
    endtask

    task automatic test_cpu_ops();
        logic [3:0]  op [5];
        logic [31:0] ad [5];
        bit          sh [5];
        logic [13:0] ev [5];
        logic [31:0] ew [5];
        int lat;
        op = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd4};
        ad = '{32'h0010_0000, 32'h0010_0000, 32'h0020_0000, 32'h0020_0000, 32'h0020_0000};
        sh = '{0, 0, 1, 0, 0};
        ev[0] = pack(0, 0, 3, 1, 0, 0, 0);
        ev[1] = pack(1, 0, 3, 0, 0, 0, 0);
        ev[2] = pack(0, 1, 1, 1, 0, 0, 0);
        ev[3] = pack(1, 1, 2, 3, 0, 0, 0);
        ev[4] = pack(1, 1, 1, 0, 2, 1, 0);
        ew = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0020_0000};
        for (int i = 0; i < 5; i++) begin
            send_req(op[i], ad[i], sh[i], lat);
            checks++;
            if ({c_vec, c_wba} !== {ev[i], ew[i]}) begin
                errors++;
                $display("FAIL cpu_ops[%0d] got vec=%h wb_addr=%h want vec=%h wb_addr=%h", i, c_vec, c_wba, ev[i], ew[i]);
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL cpu_ops_latency[%0d] got %0d want 2", i, lat);
            end
            ack_resp();
        end
    endtask

    task automatic test_snoops();
        logic [3:0]  op [3];
        logic [13:0] ev [3];
        int lat;
        op = '{4'd6, 4'd4, 4'd5};
        ev[0] = pack(1, 0, 0, 0, 1, 0, 0);
        ev[1] = pack(0, 0, 0, 0, 0, 0, 0);
        ev[2] = pack(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            send_req(op[i], 32'h0010_0000, 0, lat);
            checks++;
            if ({c_vec, c_wba} !== {ev[i], 32'h0}) begin
                errors++;
                $display("FAIL snoops[%0d] got vec=%h wb_addr=%h want vec=%h wb_addr=0", i, c_vec, c_wba, ev[i]);
            end
            ack_resp();
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [13:0] v;
        logic [31:0] w;
        send_req(0, 32'h0020_0000, 0, lat);
        checks++;
        if ({c_vec, c_wba} !== {e_vec, e_wba}) begin
            errors++;
            $display("FAIL stall_resp got vec=%h wb_addr=%h want vec=%h wb_addr=%h", c_vec, c_wba, e_vec, e_wba);
        end
        v = c_vec; w = c_wba;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({resp_valid, req_ready, resp_hit, resp_way, resp_mesi, resp_bus_op, resp_snoop, resp_wb, resp_err, resp_wb_addr}
                !== {1'b1, 1'b0, v, w}) begin
                errors++;
                $display("FAIL stall_hold[%0d] got valid=%b ready=%b vec=%h want valid=1 ready=0 vec=%h", i, resp_valid, req_ready,
                         {resp_hit, resp_way, resp_mesi, resp_bus_op, resp_snoop, resp_wb, resp_err}, v);
            end
        end
        ack_resp();
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL stall_release got valid=%b ready=%b want valid=0 ready=1", resp_valid, req_ready);
        end
    endtask

    task automatic test_clear();
        int lat;
        send_req(8, 32'h0, 0, lat);
        checks++;
        if (lat !== NSETS) begin
            errors++;
            $display("FAIL clear_cycles got %0d want %0d", lat, NSETS);
        end
        checks++;
        if ({c_vec, c_wba} !== '0) begin
            errors++;
            $display("FAIL clear_resp got vec=%h wb_addr=%h want 0", c_vec, c_wba);
        end
        ack_resp();
        checks++;
        if ({st_hits, st_misses, st_reads, st_writes} !== exp_stats()) begin
            errors++;
            $display("FAIL clear_stats got %0d/%0d/%0d/%0d want 0", st_hits, st_misses, st_reads, st_writes);
        end
    endtask

    task automatic test_fill_evict();
        int lat;
        for (int t = 1; t <= 16; t++) begin
            send_req(1, 32'(t) << 20, 0, lat);
            checks++;
            if ({c_vec, c_wba} !== {pack(0, t - 1, 2, 4, 0, 0, 0), 32'h0}) begin
                errors++;
                $display("FAIL fill_tag%0d got vec=%h wb_addr=%h want vec=%h", t, c_vec, c_wba, pack(0, t - 1, 2, 4, 0, 0, 0));
            end
            ack_resp();
        end
        send_req(0, 32'h0010_0000, 0, lat);
        checks++;
        if ({c_vec, c_wba} !== {pack(1, 0, 2, 0, 0, 0, 0), 32'h0}) begin
            errors++;
            $display("FAIL evict_hit got vec=%h wb_addr=%h want vec=%h", c_vec, c_wba, pack(1, 0, 2, 0, 0, 0, 0));
        end
        ack_resp();
        send_req(0, 32'h0110_0000, 0, lat);
        checks++;
        if ({c_vec, c_wba} !== {pack(0, 8, 3, 1, 0, 1, 0), 32'h0090_0000}) begin
            errors++;
            $display("FAIL evict_plru got vec=%h wb_addr=%h want vec=%h wb_addr=00900000", c_vec, c_wba, pack(0, 8, 3, 1, 0, 1, 0));
        end
        ack_resp();
    endtask

    task automatic test_random();
        int ops [12] = '{0, 0, 1, 1, 2, 3, 4, 6, 5, 7, 9, 12};
        int lat, hold;
        logic [31:0] addr;
        logic [3:0]  op;
        for (int i = 0; i < 400; i++) begin
            op   = 4'(ops[$urandom_range(0, 11)]);
            addr = (32'($urandom_range(1, 24)) << 20) | (32'($urandom_range(0, 3)) << 6) | 32'($urandom_range(0, 63));
            send_req(op, addr, bit'($urandom_range(0, 1)), lat);
            checks++;
            if ({c_vec, c_wba, lat} !== {e_vec, e_wba, 2}) begin
                errors++;
                $display("FAIL random[%0d] op=%0d addr=%h got vec=%h wb_addr=%h lat=%0d want vec=%h wb_addr=%h lat=2",
                         i, op, addr, c_vec, c_wba, lat, e_vec, e_wba);
            end
            hold = $urandom_range(0, 2);
            repeat (hold) @(posedge clk);
            #1;
            ack_resp();
        end
        checks++;
        if ({st_hits, st_misses, st_reads, st_writes} !== exp_stats()) begin
            errors++;
            $display("FAIL random_stats got %0d/%0d/%0d/%0d want %h", st_hits, st_misses, st_reads, st_writes, exp_stats());
        end
    endtask

    task automatic test_clear_again();
        int lat;
        test_clear();
        send_req(0, 32'h0010_0000, 0, lat);
        checks++;
        if ({c_vec, c_wba} !== {pack(0, 0, 3, 1, 0, 0, 0), 32'h0}) begin
            errors++;
            $display("FAIL clear_again_miss got vec=%h wb_addr=%h want vec=%h", c_vec, c_wba, pack(0, 0, 3, 1, 0, 0, 0));
        end
        ack_resp();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_shared = 1'b0; resp_ready = 1'b0;
        model_clear();
        test_reset();
        test_cpu_ops();
        test_snoops();
        test_stall();
        test_clear();
        test_fill_evict();
        test_random();
        test_clear_again();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
